// File: rtl/dmem_responder_if.sv
// Data-memory bus between the core (master) and the responder (slave).
// Latency: reads are combinational on Q; writes take effect at the clock edge.
// Backpressure: none on the bus itself; the slave reports readiness separately.
interface dmem_responder_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          CEN;
  logic          WEN;
  logic          OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  modport master (output CEN, WEN, OEN, A, D, input Q);
  modport slave  (input CEN, WEN, OEN, A, D, output Q);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word array with a self-clearing FSM, access counters and error flags.
// Latency: combinational read (same cycle); posted write at the rising edge; clear takes 2**AW cycles.
// Backpressure: ready=0 while clearing; accesses then are dropped and flagged. Optional macro DMEM_PARITY_EN.
module dmem_responder #(
  parameter int AW = 7,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  dmem_responder_if.slave     bus,
  input  logic                clear_req,
  output logic                ready,
  output logic                drop_err,
  output logic                par_err,
  output logic [CW-1:0]       rd_cnt,
  output logic [CW-1:0]       wr_cnt
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] mem [DEPTH];

  logic access;
  logic wr_srv;
  logic rd_srv;

  // An access is serviced only once the array is fully cleared.
  assign access = ~bus.CEN;
  assign wr_srv = ready & access & ~bus.WEN;
  assign rd_srv = ready & access & bus.WEN & ~bus.OEN;

  // Q is zero unless a serviced read is in progress, and forced low during reset.
  assign bus.Q = (rd_srv && !rst) ? mem[bus.A] : '0;

  // Clear/idle sequencer; ready is registered and tracks the IDLE state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == {AW{1'b1}}) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
            ready    <= 1'b0;
          end
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
          ready    <= 1'b0;
        end
      endcase
    end
  end

  // Single write port: the clear sweep owns it while not ready, otherwise core writes.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_addr] <= '0;
    end else if (wr_srv) begin
      mem[bus.A] <= bus.D;
    end
  end

  // Saturating counters and the sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      drop_err <= 1'b0;
    end else begin
      if (rd_srv && rd_cnt != {CW{1'b1}}) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (wr_srv && wr_cnt != {CW{1'b1}}) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (!ready && access) begin
        drop_err <= 1'b1;
      end
    end
  end

`ifdef DMEM_PARITY_EN
  // One even-parity bit per word, kept as a flat vector beside the data array.
  logic [DEPTH-1:0] par_mem;

  // Parity storage follows the data array's write port exactly.
  always_ff @(posedge clk) begin
    if (!ready) begin
      par_mem[clr_addr] <= 1'b0;
    end else if (wr_srv) begin
      par_mem[bus.A] <= ^bus.D;
    end
  end

  // Sticky parity error, checked on every serviced read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (rd_srv && ((^mem[bus.A]) != par_mem[bus.A])) begin
      par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle core's data interface; the slave end of CEN/WEN/OEN/A/D/Q.
- Provides word storage with a combinational read, so core loads complete in one cycle, and posted writes on the clock edge.
- After reset, or on request, a clear state machine zeroes the array; ready is low while it runs.
- Adds saturating access counters and a sticky protocol-error flag for the bench.

Parameters:
AW, 7, address width; DEPTH = 2**AW words
DW, 32, data word width
CW, 16, access counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
CEN  input  1  chip enable, active-low
WEN  input  1  0 = write, 1 = read (valid when CEN=0)
OEN  input  1  output enable, active-low
A  input  AW  word address
D  input  DW  write data
Q  output  DW  read data (combinational)
clear_req  input  1  one-cycle request to re-zero the array
ready  output  1  1 when accesses are serviced
drop_err  output  1  sticky; access attempted while ready=0
par_err  output  1  sticky parity error (see Optional Feature)
rd_cnt  output  CW  serviced read count, saturating
wr_cnt  output  CW  serviced write count, saturating

Behaviour:
- States are CLEAR and IDLE.
- Reset (async, rst=1):
  - state=CLEAR, clr_addr=0, ready=0.
  - drop_err, par_err, rd_cnt and wr_cnt all reset to 0.
  - Q=0 while rst=1.
  - Reset asserted mid-CLEAR restarts the clear at address 0.
- CLEAR:
  - Each clock writes 0 to mem[clr_addr], then clr_addr increments.
  - At clr_addr == DEPTH-1 the last word is written and the next state is IDLE.
  - A clear takes DEPTH cycles; with AW=7, ready rises on the 128th rising edge after reset release.
  - Core accesses are not serviced: Q=0, writes are dropped, counters hold.
  - Any cycle with CEN=0 sets drop_err.
  - clear_req is ignored.
- IDLE, ready=1:
  - Read: CEN=0, WEN=1, OEN=0 drives Q = mem[A] combinationally, same cycle. rd_cnt increments at the edge.
  - Write: CEN=0, WEN=0 updates mem[A] <= D at the rising edge. wr_cnt increments. OEN is ignored for writes.
  - During a write cycle Q=0; the new data is visible from the next cycle.
  - CEN=1, or OEN=1 on a read, drives Q=0 and counts nothing.
- Counters saturate at all-ones; they never wrap.
- clear_req=1 in IDLE:
  - Next state is CLEAR with clr_addr=0 and ready=0.
  - A write in the same cycle as clear_req is performed and counted before the clear.
- drop_err and par_err clear only on rst.
- Addresses are exact AW bits; no aliasing checks are needed.

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from D on write and 0 on clear.
  - On each serviced read, parity is recomputed over mem[A]; a mismatch sets par_err at the edge.
  - A bench-only hierarchical force of a stored parity bit is the injection method.
- Undefined: no parity storage; par_err is tied 0.

Test Plan:
- Reset release, CEN=1 held for 130 cycles -> ready=0 for cycles 1..127, ready=1 from cycle 128; read of any address -> Q=0.
- CEN=0 WEN=0 A=5 D=32'hDEADBEEF, then read A=5 OEN=0 -> Q=32'hDEADBEEF in the read cycle; wr_cnt=1, rd_cnt=1.
- Read A=5 with OEN=1 -> Q=0 and rd_cnt unchanged; write A=5 D=1 with OEN=1 -> next read returns 1.
- clear_req pulse with a write A=9 D=7 in the same cycle -> wr_cnt increments, ready=0 for 128 cycles; read A=9 after ready -> Q=0. Access during the clear -> drop_err=1.
- Preload wr_cnt to 16'hFFFE by force, issue 3 writes -> wr_cnt=16'hFFFF, held.
- With DMEM_PARITY_EN: write A=3 D=1, flip the stored parity bit, read A=3 -> par_err=1 after the edge and stays 1 until rst. Without the macro: par_err=0 throughout.
